sdp_ram_be: RTL and testbench

Parametrised simple dual-port RAM: the next generation of the team's single-clock simple dual-port RAM, with one write port (A) and one read port (B). Adds byte-lane write enables, a selectable read latency of 1 or 2, a selectable read-during-write policy, and a read-valid flag. Also adds an optional memory-clear sequencer that zeroes every word after reset. Sits behind packet/descriptor buffers wherever the current simple dual-port RAM is used.

---
 rtl/sdp_ram_be.sv | 159 +++++++++++++++
 tb/tb_sdp_ram_be.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM: byte-lane writes on port A, 1- or 2-cycle reads on port B,
// selectable same-address read-during-write policy and an optional post-reset clear.
`timescale 1ns/1ps
module sdp_ram_be #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  input  logic                             renb,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  output logic [DATA_WIDTH-1:0]            doutb,
  output logic                             doutb_valid,
  output logic                             init_busy
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

  if ((BYTE_WIDTH == 0) || ((DATA_WIDTH % BYTE_WIDTH) != 0)) begin : g_bad_width
    $error("sdp_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("sdp_ram_be: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clear_ptr, w_clear_ptr_nxt;
  logic                    r_init_busy, w_init_busy_nxt;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_doutb;
  logic                    r_doutb_valid;

  logic                    w_clearing;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic                    w_coll;
  logic [NUM_LANES-1:0]    w_lane_we;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic [DATA_WIDTH-1:0]   w_old_word;
  logic [DATA_WIDTH-1:0]   w_rd_word;

  // Clear/ready state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      r_clear_ptr <= '0;
      r_init_busy <= (CLEAR_ON_RESET != 0);
    end else begin
      r_state     <= w_state_nxt;
      r_clear_ptr <= w_clear_ptr_nxt;
      r_init_busy <= w_init_busy_nxt;
    end
  end

  // Next state: walk every address once, then stay ready until reset
  always_comb begin
    w_state_nxt     = r_state;
    w_clear_ptr_nxt = r_clear_ptr;
    w_init_busy_nxt = r_init_busy;
    case (r_state)
      ST_CLEAR: begin
        w_clear_ptr_nxt = r_clear_ptr + ADDR_WIDTH'(1);
        if (r_clear_ptr == '1) begin
          w_state_nxt     = ST_READY;
          w_init_busy_nxt = 1'b0;
        end
      end
      default: w_init_busy_nxt = 1'b0;
    endcase
  end

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_wr_en    = (r_state == ST_READY) && wena;
  assign w_rd_en    = (r_state == ST_READY) && renb;
  assign w_coll     = w_wr_en && (addra == addrb);

  // Clear sequencer borrows the write port; reset blocks every write
  assign w_lane_we = rst        ? '0 :
                     w_clearing ? '1 :
                     w_wr_en    ? wbe : '0;
  assign w_wr_addr = w_clearing ? r_clear_ptr : addra;
  assign w_wr_data = w_clearing ? '0 : dina;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign w_old_word = r_mem[addrb];

  // Write-first mode forwards the enabled lanes of a colliding write
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_rd_word[g*BYTE_WIDTH +: BYTE_WIDTH] =
      ((RDW_MODE != 0) && w_coll && wbe[g]) ? dina[g*BYTE_WIDTH +: BYTE_WIDTH]
                                            : w_old_word[g*BYTE_WIDTH +: BYTE_WIDTH];
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_p1_data;
    logic                  r_p1_valid;

    // Data stage carries no reset so it can fold into a RAM output register
    always_ff @(posedge clk) begin
      if (w_rd_en) begin
        r_p1_data <= w_rd_word;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_p1_valid    <= 1'b0;
        r_doutb_valid <= 1'b0;
        r_doutb       <= '0;
      end else begin
        r_p1_valid    <= w_rd_en;
        r_doutb_valid <= r_p1_valid;
        if (r_p1_valid) begin
          r_doutb <= r_p1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk) begin
      if (rst) begin
        r_doutb_valid <= 1'b0;
        r_doutb       <= '0;
      end else begin
        r_doutb_valid <= w_rd_en;
        if (w_rd_en) begin
          r_doutb <= w_rd_word;
        end
      end
    end
  end

  assign doutb       = r_doutb;
  assign doutb_valid = r_doutb_valid;
  assign init_busy   = r_init_busy;

endmodule

// File: tb/tb_sdp_ram_be.sv
// Directed bench for sdp_ram_be: three instances (L1/read-first/clear, L2/write-first/clear,
// L2/read-first/no-clear) share one stimulus stream and are checked against hand-computed values.
`timescale 1ns/1ps
module tb_sdp_ram_be;

  logic        clk;
  logic        rst;
  logic        wena;
  logic [3:0]  wbe;
  logic [9:0]  addra;
  logic [31:0] dina;
  logic        renb;
  logic [9:0]  addrb;

  logic [31:0] doutb0, doutb1, doutb2;
  logic        valid0, valid1, valid2;
  logic        busy0, busy1, busy2;

  int tests_run;
  int tests_failed;

  sdp_ram_be #(.READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb0), .doutb_valid(valid0), .init_busy(busy0));

  sdp_ram_be #(.READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb1), .doutb_valid(valid1), .init_busy(busy1));

  sdp_ram_be #(.READ_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_dut2 (
    .clk(clk), .rst(rst), .wena(wena), .wbe(wbe), .addra(addra), .dina(dina),
    .renb(renb), .addrb(addrb), .doutb(doutb2), .doutb_valid(valid2), .init_busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One active edge, outputs then sampled 1ns later
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wena  = 1'b0;
    renb  = 1'b0;
    wbe   = 4'h0;
    addra = '0;
    addrb = '0;
    dina  = '0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    wena = 1'b1; addra = a; dina = d; wbe = be;
    cyc();
    idle();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 1100) begin
      cyc();
      n++;
    end
    tests_run++;
    if (busy0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_ready: init_busy=%b after %0d cycles, required 0", busy0, n);
    end
  endtask

  // Pulses rst and counts cycles with init_busy high; renb held high throughout
  task automatic clear_window(input string tag);
    int  n;
    bit  any_valid;
    bit  any_busy2;
    bit  busy_diff;
    idle();
    rst = 1'b1;
    cyc();
    rst  = 1'b0;
    renb = 1'b1;
    addrb = 10'd5;
    n = (busy0 === 1'b1) ? 1 : 0;
    any_valid = 1'b0;
    any_busy2 = (busy2 !== 1'b0);
    busy_diff = (busy1 !== busy0);
    while (busy0 === 1'b1 && n < 1100) begin
      cyc();
      if (busy0 === 1'b1) n++;
      if (valid0 !== 1'b0 || valid1 !== 1'b0) any_valid = 1'b1;
      if (busy2 !== 1'b0) any_busy2 = 1'b1;
      if (busy1 !== busy0) busy_diff = 1'b1;
    end
    idle();
    cyc();
    if (valid1 !== 1'b0) any_valid = 1'b1;
    tests_run++;
    if (n != 1024) begin
      tests_failed++;
      $display("FAIL %s_busy_len: init_busy high %0d cycles, required 1024", tag, n);
    end
    tests_run++;
    if (any_valid) begin
      tests_failed++;
      $display("FAIL %s_valid_while_busy: doutb_valid seen=1, required 0", tag);
    end
    tests_run++;
    if (busy_diff) begin
      tests_failed++;
      $display("FAIL %s_busy1_track: L2 instance busy differed=1, required 0", tag);
    end
    tests_run++;
    if (any_busy2) begin
      tests_failed++;
      $display("FAIL %s_noclear_busy: no-clear instance init_busy seen=1, required 0", tag);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    cyc();
    tests_run++;
    if (doutb0 !== 32'h0 || valid0 !== 1'b0 || doutb1 !== 32'h0 || valid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: d0=%h v0=%b d1=%h v1=%b, required 0/0/0/0",
               doutb0, valid0, doutb1, valid1);
    end
    tests_run++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy: busy=%b%b%b, required 110", busy0, busy1, busy2);
    end
    rst = 1'b0;
    wait_ready();
  endtask

  task automatic test_basic();
    do_write(10'd5, 32'd350, 4'hF);
    do_write(10'd7, 32'd670, 4'hF);
    renb = 1'b1; addrb = 10'd5;
    cyc();
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'd350 || valid1 !== 1'b0 || valid2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_e1: v0=%b d0=%0d v1=%b v2=%b, required 1/350/0/0", valid0, doutb0, valid1, valid2);
    end
    addrb = 10'd7;
    cyc();
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'd670) begin
      tests_failed++;
      $display("FAIL basic_l1_rd7: v0=%b d0=%0d, required 1/670", valid0, doutb0);
    end
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'd350 || valid2 !== 1'b1 || doutb2 !== 32'd350) begin
      tests_failed++;
      $display("FAIL basic_l2_rd5: v1=%b d1=%0d v2=%b d2=%0d, required 1/350", valid1, doutb1, valid2, doutb2);
    end
    idle();
    cyc();
    tests_run++;
    if (valid0 !== 1'b0 || doutb0 !== 32'd670) begin
      tests_failed++;
      $display("FAIL basic_l1_hold: v0=%b d0=%0d, required 0/670", valid0, doutb0);
    end
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'd670 || valid2 !== 1'b1 || doutb2 !== 32'd670) begin
      tests_failed++;
      $display("FAIL basic_l2_rd7: v1=%b d1=%0d v2=%b d2=%0d, required 1/670", valid1, doutb1, valid2, doutb2);
    end
    cyc();
    tests_run++;
    if (valid1 !== 1'b0 || doutb1 !== 32'd670) begin
      tests_failed++;
      $display("FAIL basic_l2_hold: v1=%b d1=%0d, required 0/670", valid1, doutb1);
    end
  endtask

  task automatic test_byte_enable();
    do_write(10'd9, 32'hAABBCCDD, 4'hF);
    do_write(10'd9, 32'h11223344, 4'b0101);
    do_write(10'd9, 32'hFFFFFFFF, 4'b0000);
    renb = 1'b1; addrb = 10'd9;
    cyc();
    idle();
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'hAA22CC44) begin
      tests_failed++;
      $display("FAIL byte_en_l1: v0=%b d0=%h, required 1/aa22cc44", valid0, doutb0);
    end
    cyc();
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'hAA22CC44 || doutb2 !== 32'hAA22CC44) begin
      tests_failed++;
      $display("FAIL byte_en_l2: v1=%b d1=%h d2=%h, required 1/aa22cc44", valid1, doutb1, doutb2);
    end
  endtask

  task automatic test_collision();
    // Full-word write of 961 while reading the same address (mem[5]=350)
    wena = 1'b1; addra = 10'd5; dina = 32'd961; wbe = 4'hF;
    renb = 1'b1; addrb = 10'd5;
    cyc();
    wena = 1'b0; wbe = 4'h0;
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'd350) begin
      tests_failed++;
      $display("FAIL coll_rdfirst_l1: v0=%b d0=%0d, required 1/350", valid0, doutb0);
    end
    cyc();
    tests_run++;
    if (doutb0 !== 32'd961) begin
      tests_failed++;
      $display("FAIL coll_after_l1: d0=%0d, required 961", doutb0);
    end
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'd961) begin
      tests_failed++;
      $display("FAIL coll_wrfirst_l2: v1=%b d1=%0d, required 1/961", valid1, doutb1);
    end
    tests_run++;
    if (valid2 !== 1'b1 || doutb2 !== 32'd350) begin
      tests_failed++;
      $display("FAIL coll_rdfirst_l2: v2=%b d2=%0d, required 1/350", valid2, doutb2);
    end
    // Single-lane write during read of 5 (mem[5]=0x3c1)
    wena = 1'b1; addra = 10'd5; dina = 32'h12345678; wbe = 4'b0001;
    cyc();
    wena = 1'b0; wbe = 4'h0;
    tests_run++;
    if (doutb0 !== 32'h3C1 || doutb1 !== 32'd961 || doutb2 !== 32'd961) begin
      tests_failed++;
      $display("FAIL coll_prev_read: d0=%h d1=%h d2=%h, required 3c1/3c1/3c1", doutb0, doutb1, doutb2);
    end
    cyc();
    idle();
    tests_run++;
    if (doutb0 !== 32'h378) begin
      tests_failed++;
      $display("FAIL coll_lane_after_l1: d0=%h, required 378", doutb0);
    end
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'h378) begin
      tests_failed++;
      $display("FAIL coll_lane_merged: v1=%b d1=%h, required 1/378", valid1, doutb1);
    end
    tests_run++;
    if (valid2 !== 1'b1 || doutb2 !== 32'h3C1) begin
      tests_failed++;
      $display("FAIL coll_lane_old: v2=%b d2=%h, required 1/3c1", valid2, doutb2);
    end
    cyc();
    tests_run++;
    if (doutb1 !== 32'h378 || doutb2 !== 32'h378) begin
      tests_failed++;
      $display("FAIL coll_lane_after_l2: d1=%h d2=%h, required 378", doutb1, doutb2);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  addrs [5];
    logic [31:0] exp_d [5];
    addrs = '{10'd7, 10'd5, 10'd7, 10'd9, 10'd20};
    exp_d = '{32'd670, 32'h378, 32'd670, 32'hAA22CC44, 32'h0BADF00D};
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k < 5) begin
        renb = 1'b1;
        addrb = addrs[k];
      end
      // Independent write to a different address alongside the first read
      if (k == 0) begin
        wena = 1'b1; addra = 10'd20; dina = 32'h0BADF00D; wbe = 4'hF;
      end
      cyc();
      tests_run++;
      if (k < 5) begin
        if (valid0 !== 1'b1 || doutb0 !== exp_d[k]) begin
          tests_failed++;
          $display("FAIL b2b_l1_%0d: v0=%b d0=%h, required 1/%h", k, valid0, doutb0, exp_d[k]);
        end
      end else if (valid0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_l1_%0d: v0=%b, required 0", k, valid0);
      end
      tests_run++;
      if (k >= 1 && k <= 5) begin
        if (valid1 !== 1'b1 || doutb1 !== exp_d[k-1] || valid2 !== 1'b1 || doutb2 !== exp_d[k-1]) begin
          tests_failed++;
          $display("FAIL b2b_l2_%0d: v1=%b d1=%h v2=%b d2=%h, required 1/%h",
                   k, valid1, doutb1, valid2, doutb2, exp_d[k-1]);
        end
      end else if (valid1 !== 1'b0 || valid2 !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_l2_%0d: v1=%b v2=%b, required 0", k, valid1, valid2);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    do_write(10'd1023, 32'hDEADBEEF, 4'hF);
    clear_window("clear");
    renb = 1'b1; addrb = 10'd5;
    cyc();
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL clear_rd5_l1: v0=%b d0=%h, required 1/0", valid0, doutb0);
    end
    addrb = 10'd1023;
    cyc();
    idle();
    tests_run++;
    if (valid0 !== 1'b1 || doutb0 !== 32'h0 || valid1 !== 1'b1 || doutb1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL clear_rd: v0=%b d0=%h v1=%b d1=%h, required 1/0", valid0, doutb0, valid1, doutb1);
    end
    tests_run++;
    if (valid2 !== 1'b1 || doutb2 !== 32'h378) begin
      tests_failed++;
      $display("FAIL noclear_rd5: v2=%b d2=%h, required 1/378", valid2, doutb2);
    end
    cyc();
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL clear_rd1023_l2: v1=%b d1=%h, required 1/0", valid1, doutb1);
    end
    tests_run++;
    if (valid2 !== 1'b1 || doutb2 !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL noclear_rd1023: v2=%b d2=%h, required 1/deadbeef", valid2, doutb2);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (100) cyc();
    tests_run++;
    if (busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_clear_busy: init_busy=%b, required 1", busy0);
    end
    clear_window("restart");
    do_write(10'd5, 32'h55AA55AA, 4'hF);
    renb = 1'b1; addrb = 10'd5;
    cyc();
    cyc();
    tests_run++;
    if (valid1 !== 1'b1 || doutb1 !== 32'h55AA55AA) begin
      tests_failed++;
      $display("FAIL inflight_pre: v1=%b d1=%h, required 1/55aa55aa", valid1, doutb1);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    tests_run++;
    if (valid0 !== 1'b0 || doutb0 !== 32'h0 || valid1 !== 1'b0 || doutb1 !== 32'h0) begin
      tests_failed++;
      $display("FAIL inflight_rst: v0=%b d0=%h v1=%b d1=%h, required 0/0", valid0, doutb0, valid1, doutb1);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if (valid1 !== 1'b0 || doutb1 !== 32'h0 || valid0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL inflight_flush_%0d: v0=%b v1=%b d1=%h, required 0/0/0", k, valid0, valid1, doutb1);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    idle();
    cyc();
    test_reset();
    test_basic();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
